// File: rtl/sram_2p_march_bist_ctrl_if.sv
// BIST port bundle between the March C- engine (master) and one port of the
// RM_IHPSG13_2P SRAM macro (slave).
interface sram_2p_march_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  bist_en;
  logic                  bist_men;
  logic                  bist_wen;
  logic                  bist_ren;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic [DATA_WIDTH-1:0] bist_din;
  logic [DATA_WIDTH-1:0] bist_bm;
  logic [DATA_WIDTH-1:0] bist_dout;

  modport master (
    output bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    input  bist_dout
  );

  modport slave (
    input  bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    output bist_dout
  );
endinterface

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST engine for one BIST port of a dual-port SRAM macro: walks the
// six March elements, compares read data one cycle later, reports first failure.
module sram_2p_march_bist_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count,
  sram_2p_march_bist_ctrl_if.master mem
);

  typedef enum logic [3:0] {
    S_IDLE, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_DRAIN, S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d, nextElem;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wphase_q, wphase_d;
  logic                  pv_q, pv_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pexp_q, pexp_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] failAddr_q, failAddr_d;
  logic [7:0]            failCount_q, failCount_d;

  logic                  accMen, accWen, accRen;
  logic [DATA_WIDTH-1:0] accDin;
  logic                  runActive, descending, lastAddr, twoCycle;
  logic [DATA_WIDTH-1:0] rdExp, wrData;

  assign runActive  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign descending = (state_q == S_E3) || (state_q == S_E4);
  assign twoCycle   = (state_q == S_E1) || (state_q == S_E2) || (state_q == S_E3) || (state_q == S_E4);
  assign lastAddr   = descending ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign rdExp      = ((state_q == S_E2) || (state_q == S_E4)) ? ~BACKGROUND : BACKGROUND;
  assign wrData     = ((state_q == S_E1) || (state_q == S_E3)) ? ~BACKGROUND : BACKGROUND;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wphase_d    = wphase_q;
    pv_d        = 1'b0;
    paddr_d     = addr_q;
    pexp_d      = rdExp;
    fail_d      = fail_q;
    failAddr_d  = failAddr_q;
    failCount_d = failCount_q;
    accMen      = 1'b0;
    accWen      = 1'b0;
    accRen      = 1'b0;
    accDin      = '0;

    case (state_q)
      S_E0:    nextElem = S_E1;
      S_E1:    nextElem = S_E2;
      S_E2:    nextElem = S_E3;
      S_E3:    nextElem = S_E4;
      S_E4:    nextElem = S_E5;
      default: nextElem = S_DRAIN;
    endcase

    // Read issued last cycle: its data is on bist_dout now.
    if (pv_q && (mem.bist_dout != pexp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) failAddr_d = paddr_q;
      if (failCount_q != 8'hFF) failCount_d = failCount_q + 8'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_E0;
          addr_d      = '0;
          wphase_d    = 1'b0;
          fail_d      = 1'b0;
          failAddr_d  = '0;
          failCount_d = '0;
        end
      end
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
        accMen = 1'b1;
        if ((state_q == S_E5) || (twoCycle && !wphase_q)) begin
          accRen = 1'b1;
          pv_d   = 1'b1;
        end else begin
          accWen = 1'b1;
          accDin = wrData;
        end
        // Two-cycle elements only advance the address after their write cycle.
        if (twoCycle && !wphase_q) begin
          wphase_d = 1'b1;
        end else begin
          wphase_d = 1'b0;
          if (lastAddr) begin
            state_d = nextElem;
            addr_d  = ((nextElem == S_E3) || (nextElem == S_E4)) ? ADDR_MAX : '0;
          end else begin
            addr_d  = descending ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wphase_q    <= 1'b0;
      pv_q        <= 1'b0;
      paddr_q     <= '0;
      pexp_q      <= '0;
      fail_q      <= 1'b0;
      failAddr_q  <= '0;
      failCount_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wphase_q    <= wphase_d;
      pv_q        <= pv_d;
      paddr_q     <= paddr_d;
      pexp_q      <= pexp_d;
      fail_q      <= fail_d;
      failAddr_q  <= failAddr_d;
      failCount_q <= failCount_d;
    end
  end

  assign busy          = runActive;
  assign done          = (state_q == S_DONE);
  assign fail          = fail_q;
  assign fail_addr     = failAddr_q;
  assign fail_count    = failCount_q;
  assign mem.bist_en   = runActive;
  assign mem.bist_men  = accMen;
  assign mem.bist_wen  = accWen;
  assign mem.bist_ren  = accRen;
  assign mem.bist_addr = accMen ? addr_q : '0;
  assign mem.bist_din  = accDin;
  assign mem.bist_bm   = accWen ? '1 : '0;

endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// Bench for the March C- BIST engine: SRAM model with injectable faults and a
// March-table reference model checked against the DUT every run cycle.
`timescale 1ns/1ps
module tb_sram_2p_march_bist_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 256;
  localparam int RUN_CYCLES = 2561;
  localparam logic [DW-1:0] BG0  = 32'h00000000;
  localparam logic [DW-1:0] BG55 = 32'h55555555;

  typedef struct packed {
    logic          men;
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic resetn, start, start55;
  logic busy, done, fail, busy55, done55, fail55;
  logic [AW-1:0] failAddr, failAddr55;
  logic [7:0] failCount, failCount55;

  int vectors = 0;
  int errors = 0;
  int faultMode = 0;
  int cyc = 0;
  logic armed = 1'b0;
  logic runOver = 1'b0;
  op_t plan[$];
  op_t expQ[$];
  logic [DW-1:0] ram [N];

  always #5 clk = ~clk;

  sram_2p_march_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memIf();
  sram_2p_march_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memIf55();

  sram_2p_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BACKGROUND(BG0)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(failAddr), .fail_count(failCount), .mem(memIf)
  );

  sram_2p_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BACKGROUND(BG55)) dut55 (
    .clk(clk), .resetn(resetn), .start(start55), .busy(busy55), .done(done55), .fail(fail55),
    .fail_addr(failAddr55), .fail_count(failCount55), .mem(memIf55)
  );

  // Second macro has every cell stuck at 0.
  assign memIf55.bist_dout = '0;

  function automatic logic [DW-1:0] readFault(input int mode, input logic [AW-1:0] a, input logic [DW-1:0] stored);
    if (mode == 1 && a == 8'h3C) return stored | 32'h00000020;
    return stored;
  endfunction

  // SRAM with one-cycle read latency and the selected fault.
  always @(posedge clk) begin
    if (!resetn) begin
      memIf.bist_dout <= '0;
    end else if (memIf.bist_men && memIf.bist_ren) begin
      memIf.bist_dout <= readFault(faultMode, memIf.bist_addr, ram[memIf.bist_addr]);
    end
    if (resetn && memIf.bist_men && memIf.bist_wen) begin
      ram[memIf.bist_addr] <= (ram[memIf.bist_addr] & ~memIf.bist_bm) | (memIf.bist_din & memIf.bist_bm);
      if (faultMode == 2 && memIf.bist_addr == 8'h10) ram[8'h11][0] <= ~ram[8'h11][0];
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic buildOps(input logic [DW-1:0] bg);
    plan.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        logic [DW-1:0] rdv, wrv;
        a   = (e == 3 || e == 4) ? (N - 1 - i) : i;
        rdv = (e == 2 || e == 4) ? ~bg : bg;
        wrv = (e == 1 || e == 3) ? ~bg : bg;
        if (e != 0) plan.push_back('{1'b1, 1'b0, 1'b1, AW'(a), rdv});
        if (e != 5) plan.push_back('{1'b1, 1'b1, 1'b0, AW'(a), wrv});
      end
    end
    plan.push_back('{1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}});
  endtask

  task automatic modelRun(input int mode, output logic mFail, output logic [AW-1:0] mAddr, output int mCount);
    logic [DW-1:0] m [N];
    logic [DW-1:0] obs;
    for (int i = 0; i < N; i++) m[i] = '0;
    mFail = 1'b0;
    mAddr = '0;
    mCount = 0;
    foreach (plan[k]) begin
      if (plan[k].men && plan[k].wen) begin
        m[plan[k].addr] = plan[k].data;
        if (mode == 2 && plan[k].addr == 8'h10) m[8'h11][0] = ~m[8'h11][0];
      end else if (plan[k].men && plan[k].ren) begin
        obs = (mode == 3) ? '0 : readFault(mode, plan[k].addr, m[plan[k].addr]);
        if (obs !== plan[k].data) begin
          if (!mFail) mAddr = plan[k].addr;
          mFail = 1'b1;
          if (mCount < 255) mCount++;
        end
      end
    end
  endtask

  // Every run cycle the macro-side outputs must match the next planned access.
  always @(posedge clk) begin
    op_t e;
    #1;
    if (armed && !runOver) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cyc++;
        checkOutput($sformatf("cycle%0d", cyc),
          {busy, memIf.bist_en, done, memIf.bist_men, memIf.bist_wen, memIf.bist_ren,
           memIf.bist_addr, memIf.bist_din, memIf.bist_bm},
          {1'b1, 1'b1, 1'b0, e.men, e.wen, e.ren, e.addr,
           (e.wen ? e.data : {DW{1'b0}}), (e.wen ? {DW{1'b1}} : {DW{1'b0}})});
      end else begin
        checkOutput("done_entry", {busy, memIf.bist_en, done, memIf.bist_men, memIf.bist_addr, memIf.bist_bm},
                    {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}});
        checkOutput("run_length", 128'(cyc), 128'(RUN_CYCLES));
        runOver = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int mode, input int pulseAt, input int abortAt);
    logic mFail;
    logic [AW-1:0] mAddr;
    int mCount;
    faultMode = mode;
    buildOps(BG0);
    modelRun(mode, mFail, mAddr, mCount);
    expQ = plan;
    cyc = 0;
    runOver = 1'b0;
    @(negedge clk);
    start = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (abortAt > 0) begin
      repeat (abortAt) @(negedge clk);
      resetn = 1'b0;
      armed = 1'b0;
      #1;
      checkOutput("abort_status", {busy, done, fail, failAddr, failCount}, '0);
      checkOutput("abort_port", {memIf.bist_en, memIf.bist_men, memIf.bist_wen, memIf.bist_ren,
                                 memIf.bist_addr, memIf.bist_din, memIf.bist_bm}, '0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("after_abort_idle", {busy, done, memIf.bist_men, memIf.bist_en}, '0);
      return;
    end
    if (pulseAt > 1) begin
      repeat (pulseAt - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < RUN_CYCLES + 20 && !runOver; i++) @(negedge clk);
    if (!runOver) checkOutput("run_timeout", 128'(runOver), 128'(1));
    armed = 1'b0;
    checkOutput("fail_vs_model", 128'(fail), 128'(mFail));
    checkOutput("count_vs_model", 128'(failCount), 128'(mCount));
    if (mFail) checkOutput("addr_vs_model", 128'(failAddr), 128'(mAddr));
  endtask

  initial begin
    logic mFail;
    logic [AW-1:0] mAddr;
    int mCount;
    resetn = 1'b0;
    start = 1'b0;
    start55 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", {busy, done, fail, failAddr, failCount}, '0);
    checkOutput("reset_port", {memIf.bist_en, memIf.bist_men, memIf.bist_wen, memIf.bist_ren,
                               memIf.bist_addr, memIf.bist_din, memIf.bist_bm}, '0);
    checkOutput("reset_status55", {busy55, done55, fail55, failAddr55, failCount55,
                                   memIf55.bist_en, memIf55.bist_men}, '0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_access", {busy, done, memIf.bist_men}, '0);

    // Ideal memory.
    applyStimulus(0, 0, 0);
    checkOutput("ideal_fail", 128'(fail), 128'(0));
    checkOutput("ideal_count", 128'(failCount), 128'(0));

    // Bit 5 stuck-at-1 at 8'h3C.
    applyStimulus(1, 0, 0);
    checkOutput("stuck_fail", 128'(fail), 128'(1));
    checkOutput("stuck_addr", 128'(failAddr), 128'h3C);
    checkOutput("stuck_count", 128'(failCount), 128'(3));

    // Coupling fault 8'h10 -> 8'h11 bit 0.
    applyStimulus(2, 0, 0);
    checkOutput("coupling_fail", 128'(fail), 128'(1));
    checkOutput("coupling_addr", 128'(failAddr), 128'h11);

    // Start pulse mid-run is ignored; the per-cycle checks cover the sequence.
    applyStimulus(0, 100, 0);
    checkOutput("restart_ignored_fail", 128'(fail), 128'(0));

    // Reset in the middle of E2, then a clean full pass.
    applyStimulus(0, 0, 900);
    applyStimulus(0, 0, 0);
    checkOutput("post_abort_fail", 128'(fail), 128'(0));
    checkOutput("post_abort_done", 128'(done), 128'(1));

    // Background 55555555 against an all-stuck-at-0 macro.
    buildOps(BG55);
    modelRun(3, mFail, mAddr, mCount);
    @(negedge clk);
    start55 = 1'b1;
    @(negedge clk);
    start55 = 1'b0;
    for (int i = 0; i < RUN_CYCLES + 20 && !done55; i++) @(negedge clk);
    checkOutput("bg55_done", 128'(done55), 128'(1));
    checkOutput("bg55_fail", 128'(fail55), 128'(1));
    checkOutput("bg55_count", 128'(failCount55), 128'(255));
    checkOutput("bg55_addr", 128'(failAddr55), 128'h00);
    checkOutput("bg55_count_vs_model", 128'(failCount55), 128'(mCount));
    checkOutput("bg55_addr_vs_model", 128'(failAddr55), 128'(mAddr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
